sfx_sequencer: RTL and testbench

SFX_SEQUENCER -- requirements
Module: sfx_sequencer

---
 rtl/sfx_sequencer_if.sv | 21 ++
 rtl/sfx_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_sfx_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sfx_sequencer_if.sv
// Request/output bundle between the game logic and the sound-effect sequencer.
// The master side issues the effect pulses and the slave side drives the tone controls.
interface sfx_sequencer_if;
   logic        hit_pulse;
   logic        miss_pulse;
   logic        over_pulse;
   logic        tone_en;
   logic [15:0] half_period;
   logic        busy;
   logic [1:0]  sfx_id;

   modport master (
      output hit_pulse, miss_pulse, over_pulse,
      input  tone_en, half_period, busy, sfx_id
   );

   modport slave (
      input  hit_pulse, miss_pulse, over_pulse,
      output tone_en, half_period, busy, sfx_id
   );
endinterface

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: turns HIT/MISS/OVER pulses into timed tone/gap segments
// for a downstream square-wave generator.
//
// state  | meaning
// IDLE   | silent, no effect in progress
// NOTE   | tone sounding at the current note's half-period
// GAP    | silent pause between notes of a multi-note effect
module sfx_sequencer #(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int TICK_CYCLES = 50_000
) (
   input  logic          clk,
   input  logic          rst_n,
   sfx_sequencer_if.slave bus
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(TICK_CYCLES - 1);

   // half-period = CLK_FREQ / (2 * f_tone)
   localparam logic [15:0] HP_2K   = 16'(CLK_FREQ / 4000);
   localparam logic [15:0] HP_800  = 16'(CLK_FREQ / 1600);
   localparam logic [15:0] HP_600  = 16'(CLK_FREQ / 1200);
   localparam logic [15:0] HP_400  = 16'(CLK_FREQ / 800);

   localparam logic [8:0] D_HIT   = 9'd100;
   localparam logic [8:0] D_MISS  = 9'd200;
   localparam logic [8:0] D_OVER  = 9'd150;
   localparam logic [8:0] D_OLAST = 9'd300;
   localparam logic [8:0] D_GAP   = 9'd50;

   localparam logic [1:0] ID_NONE = 2'd0;
   localparam logic [1:0] ID_HIT  = 2'd1;
   localparam logic [1:0] ID_MISS = 2'd2;
   localparam logic [1:0] ID_OVER = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

   function automatic logic [15:0] note_hp(input logic [1:0] id, input logic [1:0] idx);
      logic [15:0] hp;
      hp = 16'd0;
      case (id)
         ID_HIT:  hp = HP_2K;
         ID_MISS: hp = HP_400;
         ID_OVER: begin
            case (idx)
               2'd0:    hp = HP_800;
               2'd1:    hp = HP_600;
               default: hp = HP_400;
            endcase
         end
         default: hp = 16'd0;
      endcase
      return hp;
   endfunction

   function automatic logic [8:0] note_len(input logic [1:0] id, input logic [1:0] idx);
      logic [8:0] len;
      len = 9'd1;
      case (id)
         ID_HIT:  len = D_HIT;
         ID_MISS: len = D_MISS;
         ID_OVER: len = (idx == 2'd2) ? D_OLAST : D_OVER;
         default: len = 9'd1;
      endcase
      return len;
   endfunction

   state_t          r_state, w_state;
   logic [1:0]      r_idx, w_idx;
   logic [8:0]      r_dur, w_dur;
   logic [PW-1:0]   r_presc, w_presc;
   logic            r_tone_en, w_tone_en;
   logic [15:0]     r_half_period, w_half_period;
   logic            r_busy, w_busy;
   logic [1:0]      r_sfx_id, w_sfx_id;

   logic [1:0]      w_req_id;
   logic            w_accept;
   logic            w_tick;
   logic            w_last;
   logic [1:0]      w_idx_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_idx         <= 2'd0;
         r_dur         <= 9'd0;
         r_presc       <= '0;
         r_tone_en     <= 1'b0;
         r_half_period <= 16'd0;
         r_busy        <= 1'b0;
         r_sfx_id      <= ID_NONE;
      end else begin
         r_state       <= w_state;
         r_idx         <= w_idx;
         r_dur         <= w_dur;
         r_presc       <= w_presc;
         r_tone_en     <= w_tone_en;
         r_half_period <= w_half_period;
         r_busy        <= w_busy;
         r_sfx_id      <= w_sfx_id;
      end
   end

   always_comb begin
      w_req_id = ID_NONE;
      if (bus.over_pulse)      w_req_id = ID_OVER;
      else if (bus.miss_pulse) w_req_id = ID_MISS;
      else if (bus.hit_pulse)  w_req_id = ID_HIT;

      // sfx_id doubles as the running effect's priority; it is 0 only in IDLE
      w_accept  = (w_req_id != ID_NONE) && (w_req_id >= r_sfx_id);
      w_tick    = (r_presc == PRESC_TC);
      w_last    = (r_sfx_id != ID_OVER) || (r_idx == 2'd2);
      w_idx_inc = r_idx + 2'd1;

      w_state       = r_state;
      w_idx         = r_idx;
      w_dur         = r_dur;
      w_presc       = w_tick ? '0 : r_presc + PW'(1);
      w_tone_en     = r_tone_en;
      w_half_period = r_half_period;
      w_busy        = r_busy;
      w_sfx_id      = r_sfx_id;

      if (w_accept) begin
         w_state       = S_NOTE;
         w_idx         = 2'd0;
         w_dur         = note_len(w_req_id, 2'd0) - 9'd1;
         w_presc       = '0;
         w_tone_en     = 1'b1;
         w_half_period = note_hp(w_req_id, 2'd0);
         w_busy        = 1'b1;
         w_sfx_id      = w_req_id;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_presc = '0;
            end
            S_NOTE: begin
               if (w_tick) begin
                  if (r_dur == 9'd0) begin
                     if (w_last) begin
                        w_state       = S_IDLE;
                        w_idx         = 2'd0;
                        w_tone_en     = 1'b0;
                        w_half_period = 16'd0;
                        w_busy        = 1'b0;
                        w_sfx_id      = ID_NONE;
                     end else begin
                        w_state       = S_GAP;
                        w_dur         = D_GAP - 9'd1;
                        w_tone_en     = 1'b0;
                        w_half_period = 16'd0;
                     end
                  end else begin
                     w_dur = r_dur - 9'd1;
                  end
               end
            end
            S_GAP: begin
               if (w_tick) begin
                  if (r_dur == 9'd0) begin
                     w_state       = S_NOTE;
                     w_idx         = w_idx_inc;
                     w_dur         = note_len(r_sfx_id, w_idx_inc) - 9'd1;
                     w_tone_en     = 1'b1;
                     w_half_period = note_hp(r_sfx_id, w_idx_inc);
                  end else begin
                     w_dur = r_dur - 9'd1;
                  end
               end
            end
            default: begin
               w_state = S_IDLE;
            end
         endcase
      end
   end

   assign bus.tone_en     = r_tone_en;
   assign bus.half_period = r_half_period;
   assign bus.busy        = r_busy;
   assign bus.sfx_id      = r_sfx_id;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboarded bench for sfx_sequencer: a segment-list reference model predicts the
// outputs after every clock edge and a monitor compares them against the DUT.
module tb_sfx_sequencer;

   localparam int TICK = 10;

   typedef struct packed {
      logic        tone_en;
      logic [15:0] half_period;
      logic        busy;
      logic [1:0]  sfx_id;
   } exp_t;

   logic clk;
   logic rst_n;
   sfx_sequencer_if bus ();

   sfx_sequencer #(.TICK_CYCLES(TICK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t q_exp[$];
   int   n_vec;
   int   n_err;
   int   cyc;
   int   m_id;
   int   m_start;

   // effect described as an ordered list of (half_period, ms) segments; hp 0 is a gap
   function automatic int seg_count(input int id);
      return (id == 3) ? 5 : 1;
   endfunction

   function automatic int seg_hp(input int id, input int i);
      int t[5];
      if (id == 1) return 12500;
      if (id == 2) return 62500;
      t = '{31250, 0, 41666, 0, 62500};
      return t[i];
   endfunction

   function automatic int seg_ms(input int id, input int i);
      int t[5];
      if (id == 1) return 100;
      if (id == 2) return 200;
      t = '{150, 50, 150, 50, 300};
      return t[i];
   endfunction

   function automatic int total_cycles(input int id);
      int s;
      s = 0;
      for (int i = 0; i < seg_count(id); i++) s += seg_ms(id, i) * TICK;
      return s;
   endfunction

   function automatic exp_t expect_at(input int id, input int e);
      exp_t r;
      int   acc;
      logic found;
      r = '0;
      acc = 0;
      found = 1'b0;
      if (id != 0) begin
         for (int i = 0; i < seg_count(id); i++) begin
            if (!found && e < acc + seg_ms(id, i) * TICK) begin
               found         = 1'b1;
               r.half_period = 16'(seg_hp(id, i));
               r.tone_en     = (seg_hp(id, i) != 0);
               r.busy        = 1'b1;
               r.sfx_id      = 2'(id);
            end
            acc += seg_ms(id, i) * TICK;
         end
      end
      return r;
   endfunction

   // predicts outputs after the next rising edge given the pulses presented to it
   task automatic model_edge(input logic h, input logic m, input logic o);
      int rid;
      int cur;
      cyc++;
      rid = o ? 3 : (m ? 2 : (h ? 1 : 0));
      cur = 0;
      if (m_id != 0 && (cyc - 1 - m_start) < total_cycles(m_id)) cur = m_id;
      if (rid != 0 && rid >= cur) begin
         m_id    = rid;
         m_start = cyc;
      end else if (m_id != 0 && (cyc - m_start) >= total_cycles(m_id)) begin
         m_id = 0;
      end
      q_exp.push_back(expect_at(m_id, cyc - m_start));
   endtask

   task automatic compare(input string name, input exp_t e);
      n_vec++;
      if (bus.tone_en !== e.tone_en || bus.half_period !== e.half_period ||
          bus.busy !== e.busy || bus.sfx_id !== e.sfx_id) begin
         n_err++;
         $display("FAIL %s edge=%0d got tone_en=%0b half_period=%0d busy=%0b sfx_id=%0d want tone_en=%0b half_period=%0d busy=%0b sfx_id=%0d",
                  name, cyc, bus.tone_en, bus.half_period, bus.busy, bus.sfx_id,
                  e.tone_en, e.half_period, e.busy, e.sfx_id);
      end
   endtask

   task automatic step(input logic h, input logic m, input logic o);
      bus.hit_pulse  = h;
      bus.miss_pulse = m;
      bus.over_pulse = o;
      model_edge(h, m, o);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      bus.hit_pulse  = 1'b0;
      bus.miss_pulse = 1'b0;
      bus.over_pulse = 1'b0;
      rst_n = 1'b0;
      #1;
      compare("async_reset", '0);
      m_id = 0;
      cyc++;
      q_exp.push_back('0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            compare("cycle", e);
         end
      end
   end

   initial begin : stimulus
      int r;
      int p;
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      m_id  = 0;
      m_start = 0;
      rst_n = 1'b0;
      bus.hit_pulse  = 1'b0;
      bus.miss_pulse = 1'b0;
      bus.over_pulse = 1'b0;
      repeat (3) @(negedge clk);
      compare("reset_state", '0);
      rst_n = 1'b1;
      idle(3);

      step(1'b1, 1'b0, 1'b0); idle(1010);             // HIT alone
      step(1'b0, 1'b0, 1'b1); idle(7010);             // full OVER sequence
      step(1'b0, 1'b1, 1'b0); idle(499);              // MISS, lower-priority HIT dropped
      step(1'b1, 1'b0, 1'b0); idle(1510);
      step(1'b1, 1'b0, 1'b0); idle(299);              // HIT preempted by OVER
      step(1'b0, 1'b0, 1'b1); idle(7010);
      step(1'b1, 1'b1, 1'b1); idle(100);              // simultaneous pulses
      do_reset();
      idle(5);
      step(1'b0, 1'b0, 1'b1); idle(1700);             // reset during OVER gap
      do_reset();
      step(1'b1, 1'b0, 1'b0); idle(1010);
      step(1'b0, 1'b1, 1'b0); idle(700);              // MISS retrigger
      step(1'b0, 1'b1, 1'b0); idle(2010);
      step(1'b1, 1'b0, 1'b0); idle(999);              // request on the expiry edge
      step(1'b1, 1'b0, 1'b0); idle(1010);

      for (int i = 0; i < 10000; i++) begin
         r = $urandom_range(0, 399);
         if (r < 3) begin
            p = $urandom_range(1, 7);
            step(p[0], p[1], p[2]);
         end else begin
            step(1'b0, 1'b0, 1'b0);
         end
      end
      idle(7010);

      @(posedge clk);
      #2;
      n_vec++;
      if (q_exp.size() != 0) begin
         n_err++;
         $display("FAIL drain pending=%0d want 0", q_exp.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
